edubos5_dmem_resp: RTL and testbench



---
 rtl/edubos5_dmem_resp.sv | 135 +++++++++++++
 tb/tb_edubos5_dmem_resp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/edubos5_dmem_resp.sv
// rtl/edubos5_dmem_resp.sv - eduBOS5 data-bus responder: word RAM, byte-lane writes, wait states, valid/ready response
// Optional error counter output enabled by defining EDUBOS5_DMEM_ERRCNT_EN.
module edubos5_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we_bs,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef EDUBOS5_DMEM_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [3:0] NOWR      = 4'b0000;
  localparam logic [3:0] BYTE1     = 4'b0001;
  localparam logic [3:0] BYTE2     = 4'b0010;
  localparam logic [3:0] BYTE3     = 4'b0100;
  localparam logic [3:0] BYTE4     = 4'b1000;
  localparam logic [3:0] HALFWORD1 = 4'b0011;
  localparam logic [3:0] HALFWORD2 = 4'b1100;
  localparam logic [3:0] WORD      = 4'b1111;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  we_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          in_range, we_legal, acc_ok;
  logic [AW-1:0] idx;

  always_comb begin
    case (we_q)
      NOWR, BYTE1, BYTE2, BYTE3, BYTE4, HALFWORD1, HALFWORD2, WORD: we_legal = 1'b1;
      default:                                                     we_legal = 1'b0;
    endcase
  end

  // A borrow in the base subtraction means the address lies below the window.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ((offset >> 2) < DEPTH_WORDS);
  assign acc_ok   = in_range && we_legal;
  assign idx      = offset[AW+1:2];

  assign req_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
          cnt_d   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      we_q      <= 4'd0;
      wdata_q   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        we_q    <= req_we_bs;
        wdata_q <= req_wdata;
      end
      if (state_q == ACCESS) begin
        rsp_valid <= 1'b1;
        rsp_err   <= ~acc_ok;
        rsp_rdata <= (acc_ok && we_q == NOWR) ? mem[idx] : 32'd0;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

  // Write commits only on the ACCESS exit edge; an earlier reset leaves RAM untouched.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && acc_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (we_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

`ifdef EDUBOS5_DMEM_ERRCNT_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_cnt <= 16'd0;
    end else if (state_q == ACCESS && !acc_ok && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_edubos5_dmem_resp.sv
// tb/tb_edubos5_dmem_resp.sv - table-driven bench for edubos5_dmem_resp
module tb_edubos5_dmem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_a, arst_b;
  logic        req_valid_a, req_valid_b, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_we_bs;
  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
`ifdef EDUBOS5_DMEM_ERRCNT_EN
  logic [15:0] err_cnt_a, err_cnt_b;
`endif

  int n_vec = 0;
  int n_bad = 0;

  edubos5_dmem_resp #(.DEPTH_WORDS(2048), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .arst(arst_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_we_bs(req_we_bs), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
`ifdef EDUBOS5_DMEM_ERRCNT_EN
    , .err_cnt(err_cnt_a)
`endif
  );

  edubos5_dmem_resp #(.DEPTH_WORDS(2048), .WAIT_STATES(3), .BASE_ADDR(32'h1000_0000)) dut_b (
    .clk(clk), .arst(arst_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_we_bs(req_we_bs), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
`ifdef EDUBOS5_DMEM_ERRCNT_EN
    , .err_cnt(err_cnt_b)
`endif
  );

  typedef struct {
    int          sel;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int sel, input logic [31:0] addr, input logic [3:0] we,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.sel = sel; v.addr = addr; v.we = we; v.wdata = wdata; v.rdata = rdata; v.err = err;
    vt.push_back(v);
  endtask

  function automatic logic rv(input int sel);
    return (sel == 0) ? rsp_valid_a : rsp_valid_b;
  endfunction

  // Issue one request, scramble the bus after acceptance, return response and edge latency.
  task automatic xact(input int sel, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_addr = a; req_we_bs = we; req_wdata = wd; rsp_ready = 1'b1;
    if (sel == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_addr = ~a; req_we_bs = 4'b1111; req_wdata = ~wd;
    lat = 0;
    while (!rv(sel) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = (sel == 0) ? rsp_rdata_a : rsp_rdata_b;
    er = (sel == 0) ? rsp_err_a : rsp_err_b;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          exp_errs_a;

    arst_a = 1'b1; arst_b = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0; rsp_ready = 1'b1;
    req_addr = 32'd0; req_we_bs = 4'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready_a", 32'(req_ready_a), 32'd1);
    check("reset rsp_valid_a", 32'(rsp_valid_a), 32'd0);
    check("reset rsp_rdata_a", rsp_rdata_a, 32'd0);
    check("reset rsp_err_a",   32'(rsp_err_a), 32'd0);
    check("reset req_ready_b", 32'(req_ready_b), 32'd1);
    check("reset rsp_valid_b", 32'(rsp_valid_b), 32'd0);
`ifdef EDUBOS5_DMEM_ERRCNT_EN
    check("reset err_cnt_a", 32'(err_cnt_a), 32'd0);
`endif
    @(negedge clk);
    arst_a = 1'b0; arst_b = 1'b0;

    add(0, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
    add(0, 32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_0020, 4'b0100, 32'h00AA_0000, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_0020, 4'b0011, 32'h0000_5566, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_0020, 4'b0000, 32'h0000_0000, 32'h11AA_5566, 1'b0);
    add(0, 32'h0000_0030, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_0030, 4'b0101, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    add(0, 32'h0000_0030, 4'b0110, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    add(0, 32'h0000_0030, 4'b0111, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    add(0, 32'h0000_0030, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0);
    add(0, 32'h0000_2000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(0, 32'h0000_2000, 4'b1111, 32'h1212_1212, 32'h0000_0000, 1'b1);
    add(0, 32'hFFFF_FFFC, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(0, 32'h0000_1FFC, 4'b1111, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_1FFF, 4'b0000, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0);
    add(0, 32'h0000_0013, 4'b1000, 32'hEE00_0000, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_0010, 4'b0001, 32'h0000_0077, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_0010, 4'b1100, 32'h1234_0000, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_0010, 4'b0010, 32'h0000_9900, 32'h0000_0000, 1'b0);
    add(0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'h1234_9977, 1'b0);
    add(1, 32'h0FFF_FFFC, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(1, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(1, 32'h1000_0000, 4'b1111, 32'h0000_0055, 32'h0000_0000, 1'b0);
    add(1, 32'h1000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0055, 1'b0);
    add(1, 32'h1000_2000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add(1, 32'h1000_1FFC, 4'b1111, 32'hCAFE_0001, 32'h0000_0000, 1'b0);
    add(1, 32'h1000_1FFC, 4'b0000, 32'h0000_0000, 32'hCAFE_0001, 1'b0);
    add(1, 32'h1000_0040, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b0);

    exp_errs_a = 0;
    foreach (vt[i]) begin
      xact(vt[i].sel, vt[i].addr, vt[i].we, vt[i].wdata, rd, er, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), (vt[i].sel == 0) ? 32'd2 : 32'd4);
      check($sformatf("vec%0d rdata", i), rd, vt[i].rdata);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].err));
      if (vt[i].sel == 0 && vt[i].err) exp_errs_a++;
    end

    // Backpressure: response held, a competing request must not be taken.
    @(negedge clk);
    req_addr = 32'h0000_1FFC; req_we_bs = 4'b0000; req_wdata = 32'd0;
    rsp_ready = 1'b0; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    lat = 0;
    while (!rsp_valid_a && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp latency", 32'(lat), 32'd2);
    req_addr = 32'h0000_0010; req_we_bs = 4'b1111; req_wdata = 32'h0000_0000; req_valid_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid_a), 32'd1);
      check($sformatf("bp%0d rsp_rdata", k), rsp_rdata_a, 32'hA5A5_5A5A);
      check($sformatf("bp%0d req_ready", k), 32'(req_ready_a), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("bp release rsp_rdata", rsp_rdata_a, 32'd0);
    check("bp release rsp_err",   32'(rsp_err_a), 32'd0);
    check("bp release req_ready", 32'(req_ready_a), 32'd1);
    req_valid_a = 1'b0;
    xact(0, 32'h0000_0010, 4'b0000, 32'd0, rd, er, lat);
    check("bp no stray write", rd, 32'h1234_9977);

    // Reset during the second WAIT cycle of a write on the 3-wait-state instance.
    @(negedge clk);
    req_addr = 32'h1000_0040; req_we_bs = 4'b1111; req_wdata = 32'h1234_5678; req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    @(posedge clk); #1;
    arst_b = 1'b1;
    #1;
    check("rst req_ready_b", 32'(req_ready_b), 32'd1);
    check("rst rsp_valid_b", 32'(rsp_valid_b), 32'd0);
    check("rst rsp_rdata_b", rsp_rdata_b, 32'd0);
    check("rst rsp_err_b",   32'(rsp_err_b), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_b = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst dropped rsp", 32'(rsp_valid_b), 32'd0);
    xact(1, 32'h1000_0040, 4'b0000, 32'd0, rd, er, lat);
    check("rst no write rdata", rd, 32'd0);
    check("rst no write err", 32'(er), 32'd0);
    check("rst read latency", 32'(lat), 32'd4);

`ifdef EDUBOS5_DMEM_ERRCNT_EN
    check("err_cnt_a", 32'(err_cnt_a), 32'(exp_errs_a));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
